// File: rtl/chs_conf_encoder.sv
// Channel configuration encoder: ramps a thermometer-coded chs_conf one bit per
// STEP_CYCLES toward a requested power level, with parity on chs_mode.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | level settled; req_ready high, accepts a new request
// RAMP  | stepping level toward target, one bit per STEP_CYCLES
module chs_conf_encoder #(
  parameter int STEP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_power,
  output logic [7:0] chs_conf,
  output logic       chs_mode,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  localparam logic [7:0] STEP_RELOAD = 8'(STEP_CYCLES - 1);
  localparam logic [3:0] LEVEL_MAX   = 4'd8;

  state_t     state, state_nxt;
  logic [3:0] level, level_nxt;
  logic [3:0] target, target_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       done_nxt, err_nxt;
  logic [3:0] req_clamped;
  logic [3:0] level_step;
  logic [8:0] therm_full;

  assign req_clamped = (req_power > LEVEL_MAX) ? LEVEL_MAX : req_power;
  assign level_step  = (level < target) ? level + 4'd1 : level - 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      level    <= 4'd0;
      target   <= 4'd0;
      wait_cnt <= 8'd0;
      done     <= 1'b0;
      err      <= 1'b0;
      chs_conf <= 8'h00;
      chs_mode <= 1'b0;
    end else begin
      state    <= state_nxt;
      level    <= level_nxt;
      target   <= target_nxt;
      wait_cnt <= wait_cnt_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      chs_conf <= therm_full[7:0];
      chs_mode <= level_nxt[0];
    end
  end

  always_comb begin
    state_nxt    = state;
    level_nxt    = level;
    target_nxt   = target;
    wait_cnt_nxt = wait_cnt;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          target_nxt = req_clamped;
          err_nxt    = (req_power > LEVEL_MAX);
          if (req_clamped == level) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt    = RAMP;
            wait_cnt_nxt = STEP_RELOAD;
          end
        end
      end
      RAMP: begin
        if (wait_cnt != 8'd0) begin
          wait_cnt_nxt = wait_cnt - 8'd1;
        end else begin
          level_nxt = level_step;
          if (level_step == target) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            wait_cnt_nxt = STEP_RELOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // chs_conf is built from the next level so it lands on the same edge as the step
  assign therm_full = (9'd1 << level_nxt) - 9'd1;

  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state == RAMP);

endmodule

// File: tb/tb_chs_conf_encoder.sv
// Directed bench for chs_conf_encoder: a table of single requests plus hand-written
// sequences for per-step timing, ignored mid-ramp requests, back-to-back and async reset.
module tb_chs_conf_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_power;
  logic [7:0] chs_conf;
  logic       chs_mode;
  logic       busy;
  logic       done;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  chs_conf_encoder #(.STEP_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_power (req_power),
    .chs_conf  (chs_conf),
    .chs_mode  (chs_mode),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pwr;
    logic       e_err;
    logic [7:0] e_conf;
    logic       e_mode;
    int         e_k;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [7:0] therm(input int n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return t[7:0];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, then wait (bounded) for done; k counts ticks after the accept edge.
  task automatic run_req(input string name, input logic [3:0] p, input logic e_err,
                         input logic [7:0] e_conf, input logic e_mode, input int e_k);
    int  k;
    bit  found;
    req_valid = 1'b1;
    req_power = p;
    tick();
    req_valid = 1'b0;
    check({name, "_err"}, int'(err), int'(e_err));
    k = 0;
    found = 0;
    while (!found && k < 64) begin
      if (done) found = 1;
      else begin
        tick();
        k++;
      end
    end
    check({name, "_latency"}, k, e_k);
    check({name, "_conf"}, int'(chs_conf), int'(e_conf));
    check({name, "_mode"}, int'(chs_mode), int'(e_mode));
    check({name, "_busy_end"}, int'(busy), 0);
    check({name, "_ready_end"}, int'(req_ready), 1);
  endtask

  initial begin
    int busy_cnt, done_cnt, nrdy_cnt;

    tbl[0] = '{pwr: 4'd3,  e_err: 1'b0, e_conf: 8'h07, e_mode: 1'b1, e_k: 4};
    tbl[1] = '{pwr: 4'd12, e_err: 1'b1, e_conf: 8'hFF, e_mode: 1'b0, e_k: 20};
    tbl[2] = '{pwr: 4'd8,  e_err: 1'b0, e_conf: 8'hFF, e_mode: 1'b0, e_k: 0};
    tbl[3] = '{pwr: 4'd15, e_err: 1'b1, e_conf: 8'hFF, e_mode: 1'b0, e_k: 0};
    tbl[4] = '{pwr: 4'd0,  e_err: 1'b0, e_conf: 8'h00, e_mode: 1'b0, e_k: 32};
    tbl[5] = '{pwr: 4'd1,  e_err: 1'b0, e_conf: 8'h01, e_mode: 1'b1, e_k: 4};
    tbl[6] = '{pwr: 4'd3,  e_err: 1'b0, e_conf: 8'h07, e_mode: 1'b1, e_k: 8};

    rst = 1'b1;
    req_valid = 1'b0;
    req_power = 4'd0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_conf",  int'(chs_conf),  0);
    check("rst_mode",  int'(chs_mode),  0);
    check("rst_busy",  int'(busy),      0);
    check("rst_ready", int'(req_ready), 1);
    check("rst_done",  int'(done),      0);
    check("rst_err",   int'(err),       0);
    tick();

    // 0 -> 5, every cycle checked against the step schedule
    req_valid = 1'b1;
    req_power = 4'd5;
    tick();
    req_valid = 1'b0;
    busy_cnt = 0; done_cnt = 0; nrdy_cnt = 0;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) tick();
      check($sformatf("up5_conf_k%0d", k), int'(chs_conf), int'(therm((k > 20 ? 20 : k) / 4)));
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      nrdy_cnt += int'(!req_ready);
    end
    check("up5_mode",     int'(chs_mode), 1);
    check("up5_busy_cnt", busy_cnt, 20);
    check("up5_done_cnt", done_cnt, 1);
    check("up5_nrdy_cnt", nrdy_cnt, 20);

    // 5 -> 2 with a spurious request for 7 while ramping
    req_valid = 1'b1;
    req_power = 4'd2;
    tick();
    req_valid = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      check($sformatf("dn2_conf_k%0d", k), int'(chs_conf), int'(therm(5 - (k > 12 ? 12 : k) / 4)));
      done_cnt += int'(done);
      if (k == 5) begin
        req_valid = 1'b1;
        req_power = 4'd7;
      end else begin
        req_valid = 1'b0;
      end
    end
    check("dn2_mode",     int'(chs_mode), 0);
    check("dn2_done_cnt", done_cnt, 1);

    foreach (tbl[i]) begin
      run_req($sformatf("tbl%0d", i), tbl[i].pwr, tbl[i].e_err, tbl[i].e_conf,
              tbl[i].e_mode, tbl[i].e_k);
      tick();
    end

    // equal-level request, then back-to-back request in the done cycle
    req_valid = 1'b1;
    req_power = 4'd3;
    tick();
    check("eq_done", int'(done),     1);
    check("eq_busy", int'(busy),     0);
    check("eq_conf", int'(chs_conf), 8'h07);
    check("eq_rdy",  int'(req_ready), 1);
    req_power = 4'd4;
    tick();
    req_valid = 1'b0;
    check("b2b_busy", int'(busy), 1);
    repeat (4) tick();
    check("b2b_conf", int'(chs_conf), 8'h0F);
    check("b2b_done", int'(done),     1);
    tick();

    // back to level 3, then async reset while ramping toward 8
    run_req("to3", 4'd3, 1'b0, 8'h07, 1'b1, 4);
    tick();
    req_valid = 1'b1;
    req_power = 4'd8;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    check("pre_rst_conf", int'(chs_conf), 8'h0F);
    #2;
    rst = 1'b1;
    #1;
    check("arst_conf", int'(chs_conf), 0);
    check("arst_busy", int'(busy),     0);
    check("arst_mode", int'(chs_mode), 0);
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      done_cnt += int'(done);
    end
    rst = 1'b0;
    #1;
    check("arst_ready", int'(req_ready), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      done_cnt += int'(done);
    end
    check("arst_no_done", done_cnt, 0);
    run_req("post_rst", 4'd1, 1'b0, 8'h01, 1'b1, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
